hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MiniRISC-V core. Consumes the six register-match flags from the `compare` block, plus stage status. Drives:
- write-enable and flush controls for PC and every pipeline register;
- registered EX-stage forwarding selects;
- stall sequencing for load-use, multi-cycle mul/div and data-memory wait.

It sits beside the ID stage, between `compare` and the pipeline registers.

## Interface
Parameters:
- MD_MAX, default 64: mul/div watchdog limit, in cycles spent in MD_WAIT.
- CNT_W, default 7: width of the watchdog counter; must satisfy 2^CNT_W > MD_MAX.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- zero1, zero2  in  1 each  IF_ID_rs1 / IF_ID_rs2 equals ID_EX_rd, and that rd is nonzero
- zero3, zero4  in  1 each  IF_ID_rs1 / IF_ID_rs2 equals EX_MEM_rd, and that rd is nonzero
- zeroa, zerob  in  1 each  IF_ID_rs1 / IF_ID_rs2 equals MEM_WB_rd, and that rd is nonzero
- ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite  in  1 each  stage will write rd
- ID_EX_memread  in  1  ID_EX holds a load
- branch_taken  in  1  EX resolved a taken branch or jump
- ex_muldiv  in  1  EX holds a multi-cycle mul/div op
- muldiv_done  in  1  mul/div result valid this cycle
- EX_MEM_memaccess  in  1  MEM stage performs a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  out  1 each  register enables
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a bubble (NOP) into the register
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = regfile, 10 = EX_MEM, 01 = MEM_WB
- md_timeout  out  1  sticky watchdog error flag

## Operation
FSM states: RUN, MD_WAIT, MEM_WAIT. Control outputs are combinational from state and inputs. Default in every state: all *_write = 1, all *_flush = 0.

Priority order, highest first:
1. **Mem wait:** EX_MEM_memaccess && !dmem_ready.
   - pc_write, IF_ID_write, ID_EX_write, EX_MEM_write = 0.
   - MEM_WB_flush = 1.
   - Next state: MEM_WAIT.
   - MEM_WAIT returns to RUN on the cycle dmem_ready = 1. That cycle uses the normal RUN outputs.
2. **Mul/div:** ex_muldiv && !muldiv_done.
   - pc_write, IF_ID_write, ID_EX_write = 0.
   - EX_MEM_flush = 1.
   - Next state: MD_WAIT.
   - MD_WAIT exits to RUN on muldiv_done. On that cycle all enables are 1, so the result enters EX_MEM.
3. **Branch:** branch_taken.
   - IF_ID_flush = 1, ID_EX_flush = 1.
   - Any simultaneous load-use condition is ignored, because the dependent instruction is squashed.
4. **Load-use:** ID_EX_memread && ID_EX_regwrite && (zero1 || zero2).
   - pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1.
   - Exactly one bubble. On the following cycle the load sits in EX_MEM, zero3/zero4 match, and forwarding from MEM_WB is selected.

Forward selects (registered):
- Captured on any edge where ID_EX_write = 1 and ID_EX_flush = 0.
- fwd_a next value:
  - 10 if zero1 && ID_EX_regwrite;
  - else 01 if zero3 && EX_MEM_regwrite;
  - else 00.
- fwd_b is identical, using zero2 and zero4.
- zeroa/zerob need no forward: the regfile writes first and reads second.
- When ID_EX_flush = 1 and ID_EX_write = 1, fwd_a and fwd_b load 00.
- When ID_EX_write = 0, fwd_a and fwd_b hold their value.

Watchdog:
- Counter clears on entry to MD_WAIT and increments each cycle spent in MD_WAIT. It saturates.
- When the counter reaches MD_MAX, md_timeout is set. It stays set until reset. The FSM keeps waiting.

## Timing
- Reset values: state = RUN, fwd_a = fwd_b = 00, counter = 0, md_timeout = 0. Combinational outputs then take their RUN defaults.
- Reset asserted mid-stall returns immediately to RUN, with no pending flush.
- Load-use costs exactly one stall cycle.
- Taken branch costs exactly a 2-cycle penalty; no registered delay.
- Mul/div of latency N (done asserted N cycles after the op enters EX) costs N stall cycles.
- MEM_WAIT takes precedence: if a mul/div sits in EX while MEM waits, EX is also frozen. MD_WAIT is not entered until MEM releases.
- muldiv_done in the same cycle the op first enters EX gives zero stall; the FSM stays in RUN.

## Structure
- Shared package `pipe_pkg`:
  - state enum: RUN, MD_WAIT, MEM_WAIT;
  - forward-select localparams: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_EX = 2'b10.
- Sub-module `fwd_sel_reg`: the registered forward-select logic, instantiated once each for the a and b operands.
- FSM, priority logic and watchdog live in the top level.

## Test plan
- **Reset:** rst_n low mid-MD_WAIT.
  - Expect all *_write = 1, flushes 0, fwd_a = fwd_b = 00, md_timeout = 0 immediately.
- **Load-use:** lw x5 followed by add x6, x5, x1 (zero1 = 1, ID_EX_memread = 1).
  - Expect one cycle of pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1.
  - Expect fwd_a = 01 on the add's EX cycle.
- **ALU back-to-back:** add x3 followed by sub x4, x3, x3 (zero1 = zero2 = 1, ID_EX_regwrite = 1).
  - Expect no stall, and fwd_a = fwd_b = 10 on the next cycle.
- **Branch with load-use:** branch_taken = 1 together with a load-use condition.
  - Expect IF_ID_flush = ID_EX_flush = 1 and pc_write = 1, i.e. no stall.
- **Mul/div:** ex_muldiv = 1 with muldiv_done after 5 cycles.
  - Expect 5 cycles of EX_MEM_flush = 1 with PC, IF_ID and ID_EX frozen, then RUN.
  - With MD_MAX = 4, expect md_timeout = 1 and sticky.
- **Mem wait during mul/div:** dmem_ready held low 3 cycles while ex_muldiv = 1.
  - Expect MEM_WAIT for 3 cycles with MEM_WB_flush = 1 and EX_MEM_write = 0.
  - Then MD_WAIT is entered.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the MiniRISC-V pipeline control: stall FSM states and
// EX-stage operand forward-select encodings.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    // The younger producer (now in ID_EX, next in EX_MEM) wins over the older one.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EX;
        else if (mem_hit)
            return FWD_MEM;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_sel_reg.sv
// Registered EX-stage forward select for one source operand; advances with
// the ID_EX register so the select lines up with the instruction it serves.
module fwd_sel_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic       ex_match,
    input  logic       ex_regwrite,
    input  logic       mem_match,
    input  logic       mem_regwrite,
    output logic [1:0] fwd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd <= FWD_RF;
        end else if (load) begin
            fwd <= clear ? FWD_RF
                         : fwd_pick(ex_match && ex_regwrite, mem_match && mem_regwrite);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation, stall FSM
// with mul/div watchdog, and registered EX forward selects.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MD_MAX = 64,
    parameter int unsigned CNT_W  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       zero1,
    input  logic       zero2,
    input  logic       zero3,
    input  logic       zero4,
    input  logic       zeroa,
    input  logic       zerob,
    input  logic       ID_EX_regwrite,
    input  logic       EX_MEM_regwrite,
    input  logic       MEM_WB_regwrite,
    input  logic       ID_EX_memread,
    input  logic       branch_taken,
    input  logic       ex_muldiv,
    input  logic       muldiv_done,
    input  logic       EX_MEM_memaccess,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       ID_EX_write,
    output logic       EX_MEM_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic       MEM_WB_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_timeout
);

    localparam logic [CNT_W:0] MD_LIMIT = (CNT_W + 1)'(MD_MAX);

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W:0]   md_cnt_inc;
    logic           mem_stall;
    logic           md_stall;
    logic           branch_flush;
    logic           load_use;

    // MEM_WB hazards are resolved by the regfile writing before it reads.
    logic wb_match_unused;
    assign wb_match_unused = ^{zeroa, zerob, MEM_WB_regwrite};

    // Gating with rst_n makes the RUN defaults visible as soon as reset asserts.
    always_comb begin
        mem_stall    = rst_n && EX_MEM_memaccess && !dmem_ready;
        md_stall     = rst_n && ex_muldiv && !muldiv_done;
        branch_flush = rst_n && branch_taken;
        load_use     = rst_n && ID_EX_memread && ID_EX_regwrite && (zero1 || zero2);
    end

    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        if (mem_stall) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_flush = 1'b1;
        end else if (md_stall) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
        end else if (branch_flush) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    always_comb begin
        state_next = RUN;
        if (mem_stall)
            state_next = MEM_WAIT;
        else if (md_stall)
            state_next = MD_WAIT;
    end

    assign md_cnt_inc = {1'b0, md_cnt} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state != MD_WAIT && state_next == MD_WAIT)
                md_cnt <= '0;
            else if (state == MD_WAIT && md_cnt != '1)
                md_cnt <= md_cnt_inc[CNT_W-1:0];
            if (state == MD_WAIT && md_cnt_inc >= MD_LIMIT)
                md_timeout <= 1'b1;
        end
    end

    fwd_sel_reg u_fwd_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (ID_EX_write),
        .clear        (ID_EX_flush),
        .ex_match     (zero1),
        .ex_regwrite  (ID_EX_regwrite),
        .mem_match    (zero3),
        .mem_regwrite (EX_MEM_regwrite),
        .fwd          (fwd_a)
    );

    fwd_sel_reg u_fwd_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (ID_EX_write),
        .clear        (ID_EX_flush),
        .ex_match     (zero2),
        .ex_regwrite  (ID_EX_regwrite),
        .mem_match    (zero4),
        .mem_regwrite (EX_MEM_regwrite),
        .fwd          (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle's stimulus pushes its expected
// outputs to a queue that a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       zero1, zero2, zero3, zero4, zeroa, zerob;
    logic       ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite;
    logic       ID_EX_memread, branch_taken, ex_muldiv, muldiv_done;
    logic       EX_MEM_memaccess, dmem_ready;
    logic       pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
    logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       md_timeout;

    typedef struct {
        string      nm;
        logic [3:0] wr;
        logic [3:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] act_wr, act_fl;

    hazard_ctrl #(.MD_MAX(4), .CNT_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .zero1            (zero1),
        .zero2            (zero2),
        .zero3            (zero3),
        .zero4            (zero4),
        .zeroa            (zeroa),
        .zerob            (zerob),
        .ID_EX_regwrite   (ID_EX_regwrite),
        .EX_MEM_regwrite  (EX_MEM_regwrite),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .ID_EX_memread    (ID_EX_memread),
        .branch_taken     (branch_taken),
        .ex_muldiv        (ex_muldiv),
        .muldiv_done      (muldiv_done),
        .EX_MEM_memaccess (EX_MEM_memaccess),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .IF_ID_write      (IF_ID_write),
        .ID_EX_write      (ID_EX_write),
        .EX_MEM_write     (EX_MEM_write),
        .IF_ID_flush      (IF_ID_flush),
        .ID_EX_flush      (ID_EX_flush),
        .EX_MEM_flush     (EX_MEM_flush),
        .MEM_WB_flush     (MEM_WB_flush),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .md_timeout       (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wr = {pc, IF_ID, ID_EX, EX_MEM}; fl = {IF_ID, ID_EX, EX_MEM, MEM_WB}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_wr = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write};
            act_fl = {IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};
            total++;
            if ({act_wr, act_fl, fwd_a, fwd_b, md_timeout} !== {e.wr, e.fl, e.fa, e.fb, e.to}) begin
                bad++;
                $display("FAIL %s: got wr=%b fl=%b fa=%b fb=%b to=%b, want wr=%b fl=%b fa=%b fb=%b to=%b",
                         e.nm, act_wr, act_fl, fwd_a, fwd_b, md_timeout,
                         e.wr, e.fl, e.fa, e.fb, e.to);
            end
        end
    end

    task automatic idle();
        zero1 = 0; zero2 = 0; zero3 = 0; zero4 = 0; zeroa = 0; zerob = 0;
        ID_EX_regwrite = 0; EX_MEM_regwrite = 0; MEM_WB_regwrite = 0;
        ID_EX_memread = 0; branch_taken = 0; ex_muldiv = 0; muldiv_done = 0;
        EX_MEM_memaccess = 0; dmem_ready = 1;
    endtask

    task automatic chk(input string nm, input logic [3:0] wr, input logic [3:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic to);
        exp_t x;
        x.nm = nm; x.wr = wr; x.fl = fl; x.fa = fa; x.fb = fb; x.to = to;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        chk("reset", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        rst_n = 1;
        chk("post_reset", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);

        // add x3 ; sub x4, x3, x3
        idle(); zero1 = 1; zero2 = 1; ID_EX_regwrite = 1;
        chk("alu_b2b_id", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        idle();
        chk("alu_b2b_ex", 4'b1111, 4'b0000, 2'b10, 2'b10, 0);
        idle(); zero1 = 1; zero3 = 1; zero4 = 1; ID_EX_regwrite = 1; EX_MEM_regwrite = 1;
        chk("fwd_prio_id", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        idle(); zero1 = 1; zero3 = 1; EX_MEM_regwrite = 1; zeroa = 1; zerob = 1; MEM_WB_regwrite = 1;
        chk("fwd_prio_ex", 4'b1111, 4'b0000, 2'b10, 2'b01, 0);
        idle();
        chk("fwd_mem_only", 4'b1111, 4'b0000, 2'b01, 2'b00, 0);
        idle();
        chk("fwd_idle", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);

        // lw x5 ; add x6, x5, x1
        idle(); ID_EX_memread = 1; ID_EX_regwrite = 1; zero1 = 1;
        chk("ldu_stall", 4'b0011, 4'b0100, 2'b00, 2'b00, 0);
        idle(); zero3 = 1; EX_MEM_regwrite = 1;
        chk("ldu_bubble", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        idle();
        chk("ldu_add_ex", 4'b1111, 4'b0000, 2'b01, 2'b00, 0);

        idle(); branch_taken = 1; ID_EX_memread = 1; ID_EX_regwrite = 1; zero1 = 1;
        chk("br_ldu", 4'b1111, 4'b1100, 2'b00, 2'b00, 0);
        idle();
        chk("br_after", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);

        // mul/div latency 3: forward selects hold through the stall
        idle(); zero1 = 1; zero2 = 1; ID_EX_regwrite = 1;
        chk("md3_pre", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        idle(); ex_muldiv = 1;
        chk("md3_s0", 4'b0001, 4'b0010, 2'b10, 2'b10, 0);
        chk("md3_s1", 4'b0001, 4'b0010, 2'b10, 2'b10, 0);
        chk("md3_s2", 4'b0001, 4'b0010, 2'b10, 2'b10, 0);
        muldiv_done = 1;
        chk("md3_done", 4'b1111, 4'b0000, 2'b10, 2'b10, 0);
        idle();
        chk("md3_after", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);

        // mul/div latency 5 against a limit of 4
        idle(); ex_muldiv = 1;
        chk("md5_s0", 4'b0001, 4'b0010, 2'b00, 2'b00, 0);
        chk("md5_s1", 4'b0001, 4'b0010, 2'b00, 2'b00, 0);
        chk("md5_s2", 4'b0001, 4'b0010, 2'b00, 2'b00, 0);
        chk("md5_s3", 4'b0001, 4'b0010, 2'b00, 2'b00, 0);
        chk("md5_s4", 4'b0001, 4'b0010, 2'b00, 2'b00, 0);
        muldiv_done = 1;
        chk("md5_done", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);
        idle();
        chk("md5_sticky1", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);
        chk("md5_sticky2", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);

        // memory wait with a mul/div in EX, then MD_WAIT
        idle(); EX_MEM_memaccess = 1; dmem_ready = 0; ex_muldiv = 1;
        chk("mw_s0", 4'b0000, 4'b0001, 2'b00, 2'b00, 1);
        branch_taken = 1;
        chk("mw_s1_br", 4'b0000, 4'b0001, 2'b00, 2'b00, 1);
        branch_taken = 0;
        chk("mw_s2", 4'b0000, 4'b0001, 2'b00, 2'b00, 1);
        dmem_ready = 1;
        chk("mw_rel_md", 4'b0001, 4'b0010, 2'b00, 2'b00, 1);
        EX_MEM_memaccess = 0; muldiv_done = 1;
        chk("mw_md_done", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);

        idle(); ex_muldiv = 1; muldiv_done = 1;
        chk("md_zero", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);

        // reset asserted in the middle of MD_WAIT with the stall inputs still high
        idle(); zero1 = 1; ID_EX_regwrite = 1;
        chk("rst_pre", 4'b1111, 4'b0000, 2'b00, 2'b00, 1);
        idle(); ex_muldiv = 1;
        chk("rst_md0", 4'b0001, 4'b0010, 2'b10, 2'b00, 1);
        chk("rst_md1", 4'b0001, 4'b0010, 2'b10, 2'b00, 1);
        rst_n = 0;
        chk("rst_mid_md", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);
        rst_n = 1;
        idle();
        chk("rst_release", 4'b1111, 4'b0000, 2'b00, 2'b00, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: pending=%0d want 0", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
